// File: rtl/z_core_pkg.sv
// Shared definitions for the core memory interface: opcodes, funct3
// size codes, one-hot state layout and the access legality rule.
package z_core_pkg;

  // Core opcodes that reach the memory interface
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 size/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // One-hot state bit positions
  localparam int S_IDLE_BIT = 0;
  localparam int S_REQ_BIT  = 1;
  localparam int S_RESP_BIT = 2;
  localparam int S_DONE_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_RESP = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  // An access is illegal for unknown sizes, misalignment, or an
  // unsigned size code on a store.
  function automatic logic access_illegal(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo,
                                          input logic       we);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = addr_lo[0];
      F3_HU:   bad = addr_lo[0] | we;
      F3_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/z_core_lsu_align.sv
// Byte-lane alignment: store strobes and data shifting, load extraction
// with sign or zero extension. Purely combinational.
module z_core_lsu_align
  import z_core_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [4:0]  shamt_s;
  logic [15:0] lane_s;

  assign shamt_s = {addr_lo, 3'b000};
  assign lane_s  = 16'(bus_word >> shamt_s);

  // Store side: byte strobes for the addressed lanes and shifted data
  always_comb begin
    wstrb = 4'b0000;
    if (funct3 == F3_W) begin
      wdata = store_data;
    end else begin
      wdata = store_data << shamt_s;
    end
    if (we) begin
      case (funct3)
        F3_B, F3_BU: wstrb = 4'b0001 << addr_lo;
        F3_H, F3_HU: wstrb = 4'b0011 << addr_lo;
        F3_W:        wstrb = 4'b1111;
        default:     wstrb = 4'b0000;
      endcase
    end else begin
      wstrb = 4'b0000;
    end
  end

  // Load side: pick the addressed byte/half and extend it to 32 bits
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_B:    load_data = {{24{lane_s[7]}}, lane_s[7:0]};
      F3_BU:   load_data = {24'h00_0000, lane_s[7:0]};
      F3_H:    load_data = {{16{lane_s[15]}}, lane_s[15:0]};
      F3_HU:   load_data = {16'h0000, lane_s[15:0]};
      F3_W:    load_data = bus_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/z_core_mem_if.sv
// Core-to-bus memory interface: captures one core access, checks its
// legality, runs a valid/ready request and waits (with timeout) for the
// single response, then returns a one-cycle ack to the core.
module z_core_mem_if
  import z_core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_funct3,
  output logic        core_ack,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rerr
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_r;
  state_e            state_s;
  logic              we_r;
  logic [1:0]        addr_lo_r;
  logic [2:0]        funct3_r;
  logic [CNT_W-1:0]  tmo_cnt_r;

  logic              illegal_s;
  logic              timeout_s;
  logic [1:0]        sel_addr_lo_s;
  logic [2:0]        sel_funct3_s;
  logic              sel_we_s;
  logic [3:0]        wstrb_s;
  logic [31:0]       wdata_s;
  logic [31:0]       load_data_s;

  assign illegal_s = access_illegal(core_funct3, core_addr[1:0], core_we);
  // The final RESP cycle is the one where the counter holds TIMEOUT_CYCLES-1
  assign timeout_s = (tmo_cnt_r == CNT_LAST);

  // Aligner sees live core fields while idle, captured fields afterwards
  always_comb begin
    if (state_r[S_IDLE_BIT]) begin
      sel_addr_lo_s = core_addr[1:0];
      sel_funct3_s  = core_funct3;
      sel_we_s      = core_we;
    end else begin
      sel_addr_lo_s = addr_lo_r;
      sel_funct3_s  = funct3_r;
      sel_we_s      = we_r;
    end
  end

  z_core_lsu_align u_align (
    .addr_lo    (sel_addr_lo_s),
    .funct3     (sel_funct3_s),
    .we         (sel_we_s),
    .store_data (core_wdata),
    .bus_word   (bus_rdata),
    .wstrb      (wstrb_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (core_req) begin
          state_s = illegal_s ? ST_DONE : ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_ready) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (bus_rvalid || timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Capture the access, drive the bus and produce the completion pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_r       <= 1'b0;
      addr_lo_r  <= 2'b00;
      funct3_r   <= 3'b000;
      tmo_cnt_r  <= {CNT_W{1'b0}};
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= 32'h0000_0000;
      bus_valid  <= 1'b0;
      bus_addr   <= 32'h0000_0000;
      bus_we     <= 1'b0;
      bus_wstrb  <= 4'b0000;
      bus_wdata  <= 32'h0000_0000;
    end else begin
      // Ack, err and rdata only carry meaning during the DONE cycle
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= 32'h0000_0000;
      case (state_r)
        ST_IDLE: begin
          if (core_req) begin
            we_r      <= core_we;
            addr_lo_r <= core_addr[1:0];
            funct3_r  <= core_funct3;
            if (illegal_s) begin
              core_ack <= 1'b1;
              core_err <= 1'b1;
            end else begin
              bus_valid <= 1'b1;
              bus_addr  <= {core_addr[31:2], 2'b00};
              bus_we    <= core_we;
              bus_wstrb <= wstrb_s;
              bus_wdata <= wdata_s;
            end
          end
        end
        ST_REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            tmo_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_RESP: begin
          if (bus_rvalid) begin
            core_ack   <= 1'b1;
            core_err   <= bus_rerr;
            core_rdata <= (bus_rerr || we_r) ? 32'h0000_0000 : load_data_s;
          end else if (timeout_s) begin
            core_ack <= 1'b1;
            core_err <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          // DONE: pulse already issued, nothing further to drive
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z_core_mem_if.sv
// Scoreboard bench for z_core_mem_if: a stimulus process pushes expected
// core responses and bus requests, monitors pop and compare them.
module tb_z_core_mem_if;

  localparam int TMO = 8;

  logic        clk, reset_n;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_funct3;
  logic        core_ack, core_err;
  logic [31:0] core_rdata;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid, bus_rerr;
  logic [31:0] bus_rdata;

  z_core_mem_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_ack(core_ack), .core_rdata(core_rdata), .core_err(core_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rerr(bus_rerr)
  );

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          issue;
    int          lat;
  } core_exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  core_exp_t core_q[$];
  bus_exp_t  bus_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          cfg_rd = 0, cfg_rvd = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        cfg_rerr = 1'b0;
  int          wait_cnt = 0, resp_cnt = 0;
  bit          resp_pending = 1'b0;
  bit          req_held = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (from the access rules) ----------
  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit ref_illegal(input logic we, input logic [31:0] addr, input logic [2:0] f3);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (addr % 32'(ref_size(f3))) != 32'd0;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [31:0] addr, input logic [2:0] f3);
    int m;
    m = ((1 << ref_size(f3)) - 1) << int'(addr % 32'd4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d);
    if (ref_size(f3) == 4) return d;
    return d << (8 * int'(addr % 32'd4));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word);
    longint v;
    int     bits;
    bits = 8 * ref_size(f3);
    v = (longint'(word) >> (8 * int'(addr % 32'd4))) & ((longint'(1) << bits) - 1);
    if (!f3[2] && bits < 32 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // ---------------- bus slave ----------------------------------------
  initial begin
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_rerr = 1'b0;
    forever begin
      @(negedge clk);
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      if (bus_valid === 1'b1) begin
        resp_pending = 1'b0;
        if (wait_cnt >= cfg_rd) begin
          bus_ready = 1'b1; wait_cnt = 0; resp_pending = 1'b1; resp_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else if (resp_pending) begin
        if (resp_cnt == cfg_rvd) begin
          bus_rvalid = 1'b1; bus_rdata = cfg_rdata; bus_rerr = cfg_rerr; resp_pending = 1'b0;
        end else begin
          resp_cnt++;
        end
      end
    end
  end

  // ---------------- monitors -----------------------------------------
  core_exp_t ce_m;
  always @(posedge clk) begin
    #1;
    if (core_ack === 1'b1) begin
      if (core_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        ce_m = core_q.pop_front();
        chk({ce_m.name, "_err"}, 32'(core_err), 32'(ce_m.err));
        chk({ce_m.name, "_rdata"}, core_rdata, ce_m.rdata);
        chk({ce_m.name, "_ack_cycle"}, 32'(cyc - ce_m.issue + 1), 32'(ce_m.lat));
      end
    end
  end

  bus_exp_t be_m;
  always @(negedge clk) begin
    #2;
    if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
      if (bus_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_bus_req: got addr 0x%08h expected no request", bus_addr);
      end else begin
        be_m = bus_q.pop_front();
        chk({be_m.name, "_bus_addr"}, bus_addr, be_m.addr);
        chk({be_m.name, "_bus_we"}, 32'(bus_we), 32'(be_m.we));
        chk({be_m.name, "_bus_wstrb"}, 32'(bus_wstrb), 32'(be_m.wstrb));
        if (be_m.we) chk({be_m.name, "_bus_wdata"}, bus_wdata, be_m.wdata);
      end
    end
  end

  // ---------------- stimulus -----------------------------------------
  // Entered at a negedge; returns at the negedge of an IDLE cycle, or of
  // the ack cycle when keep=1 (next call then issues back-to-back).
  task automatic access(input string nm, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3, input int rd,
                        input int rvd, input logic [31:0] rdat, input logic rerr, input bit keep);
    core_exp_t ce;
    bus_exp_t  be;
    bit ill, tmo, got, b2b;
    b2b = req_held;
    ill = ref_illegal(we, addr, f3);
    tmo = !ill && (rvd >= TMO);
    ce.name  = nm;
    ce.err   = ill | tmo | rerr;
    ce.rdata = (ce.err || we) ? 32'h0 : ref_load(addr, f3, rdat);
    ce.issue = b2b ? cyc + 1 : cyc;
    ce.lat   = ill ? 2 : (tmo ? 3 + rd + TMO : 4 + rd + rvd);
    core_q.push_back(ce);
    if (!ill) begin
      be.name = nm; be.addr = addr & 32'hFFFF_FFFC; be.we = we;
      be.wstrb = we ? ref_wstrb(addr, f3) : 4'b0000;
      be.wdata = ref_wdata(addr, f3, wd);
      bus_q.push_back(be);
    end
    cfg_rd = rd; cfg_rvd = rvd; cfg_rdata = rdat; cfg_rerr = rerr;
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd; core_funct3 = f3;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (core_ack === 1'b1) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        if (i > 0 || !b2b) begin
          core_addr = $urandom; core_wdata = $urandom;
          core_funct3 = 3'($urandom_range(0, 7)); core_we = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within 200 cycles", nm);
    end
    @(negedge clk);
    if (keep) begin
      req_held = 1'b1;
    end else begin
      core_req = 1'b0; req_held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ack"},   32'(core_ack),  32'd0);
    chk({nm, "_err"},   32'(core_err),  32'd0);
    chk({nm, "_valid"}, 32'(bus_valid), 32'd0);
    chk({nm, "_we"},    32'(bus_we),    32'd0);
    chk({nm, "_wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({nm, "_rdata"}, core_rdata,     32'd0);
    chk({nm, "_addr"},  bus_addr,       32'd0);
    chk({nm, "_wdata"}, bus_wdata,      32'd0);
  endtask

  initial begin
    int rd, rvd;
    bit keep;
    reset_n = 1'b0; core_req = 1'b0; core_we = 1'b0;
    core_addr = 32'h0; core_wdata = 32'h0; core_funct3 = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // Directed accesses
    access("lw_100",  1'b0, 32'h100, 32'h0,    3'b010, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    access("lb_103",  1'b0, 32'h103, 32'h0,    3'b000, 0, 0, 32'h80FF0000, 1'b0, 1'b1);
    access("lbu_103", 1'b0, 32'h103, 32'h0,    3'b100, 0, 0, 32'h80FF0000, 1'b0, 1'b0);
    access("sh_102",  1'b1, 32'h102, 32'h1234, 3'b001, 0, 0, 32'h0,        1'b0, 1'b0);
    access("lw_101",  1'b0, 32'h101, 32'h0,    3'b010, 0, 0, 32'h0,        1'b0, 1'b0);
    access("sbu_ill", 1'b1, 32'h104, 32'h55,   3'b100, 0, 0, 32'h0,        1'b0, 1'b0);
    access("f3_011",  1'b0, 32'h108, 32'h0,    3'b011, 0, 0, 32'h0,        1'b0, 1'b0);
    access("lh_rerr", 1'b0, 32'h202, 32'h0,    3'b001, 1, 2, 32'h12345678, 1'b1, 1'b0);
    access("lhu_wait",1'b0, 32'h206, 32'h0,    3'b101, 2, 3, 32'h8001FFFF, 1'b0, 1'b0);
    access("lw_tmo",  1'b0, 32'h300, 32'h0,    3'b010, 3, TMO + 4, 32'hCAFEF00D, 1'b0, 1'b0);
    repeat (12) @(negedge clk);

    // Reset while waiting in RESP: access is dropped, stray rvalid ignored
    cfg_rd = 0; cfg_rvd = 5; cfg_rdata = 32'h11112222; cfg_rerr = 1'b0;
    begin
      bus_exp_t be;
      be.name = "rst_lw"; be.addr = 32'h208; be.we = 1'b0; be.wstrb = 4'b0000; be.wdata = 32'h0;
      bus_q.push_back(be);
    end
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h208; core_funct3 = 3'b010;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset_n = 1'b0; core_req = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(negedge clk);
    access("sw_after_rst", 1'b1, 32'h204, 32'hA5A55A5A, 3'b010, 0, 0, 32'h0, 1'b0, 1'b0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      rd   = $urandom_range(0, 3);
      rvd  = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, 3);
      keep = (n != 39) && ($urandom_range(0, 2) == 0);
      access("rnd", 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 255)),
             $urandom, 3'($urandom_range(0, 7)), rd, rvd, $urandom,
             1'($urandom_range(0, 7) == 0), keep);
    end

    repeat (20) @(negedge clk);
    chk("core_q_drained", 32'(core_q.size()), 32'd0);
    chk("bus_q_drained",  32'(bus_q.size()),  32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
